divide: RTL and testbench

Iterative signed/unsigned integer divider. It is the inverse companion of the team's Baugh-Wooley `multiply` datapath and shares its operand conventions: per-operand signedness flags and `p_width`-bit operands. It computes quotient and remainder with one restoring step per cycle and exchanges operands and results over valid/ready handshakes. It sits beside `multiply` in the arithmetic unit.

---
 rtl/divide.sv | 116 +++++++++++
 tb/tb_divide.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Per-operand signedness; results wrap modulo 2^p_width.
module divide #(
  parameter int p_width = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [p_width-1:0] a_i,
  input  logic [p_width-1:0] b_i,
  input  logic               a_signed_i,
  input  logic               b_signed_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [p_width-1:0] quotient_o,
  output logic [p_width-1:0] remainder_o,
  output logic               div_by_zero_o
);

  localparam int cw = (p_width > 2) ? $clog2(p_width) : 1;
  localparam logic [cw-1:0] last = cw'(p_width - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [cw-1:0]      cnt;
  logic [p_width-1:0] r;
  logic [p_width-1:0] q;
  logic [p_width-1:0] b_mag;
  logic               q_neg;
  logic               r_neg;
  logic               dz;

  logic               a_neg;
  logic               b_neg;
  logic [p_width-1:0] a_mag;
  logic [p_width-1:0] b_abs;
  logic [p_width:0]   r_sh;
  logic [p_width:0]   diff;
  logic               ge;
  logic [p_width-1:0] r_nx;
  logic [p_width-1:0] q_nx;

  assign ready_o = (state == IDLE) & ~rst_i;

  always_comb begin
    a_neg = a_signed_i & a_i[p_width-1];
    b_neg = b_signed_i & b_i[p_width-1];
    a_mag = a_neg ? -a_i : a_i;
    b_abs = b_neg ? -b_i : b_i;
    r_sh  = {r, q[p_width-1]};
    diff  = r_sh - {1'b0, b_mag};
    // r_sh < 2*|b|, so a borrow out of the top bit means r_sh < |b|
    ge    = ~diff[p_width];
    r_nx  = ge ? diff[p_width-1:0] : r_sh[p_width-1:0];
    q_nx  = {q[p_width-2:0], ge};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      r             <= '0;
      q             <= '0;
      b_mag         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      dz            <= 1'b0;
      valid_o       <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            q     <= a_mag;
            b_mag <= b_abs;
            r     <= '0;
            cnt   <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            dz    <= (b_i == '0);
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == last) begin
            state         <= DONE;
            valid_o       <= 1'b1;
            quotient_o    <= dz ? '1
                           : (q_neg ? -q_nx : q_nx);
            remainder_o   <= r_neg ? -r_nx : r_nx;
            div_by_zero_o <= dz;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed vectors, random vectors
// against an integer-arithmetic model, backpressure and reset abort.
module tb_divide;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] a_i = '0;
  logic [3:0] b_i = '0;
  logic       a_signed_i = 1'b0;
  logic       b_signed_i = 1'b0;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [3:0] quotient_o;
  logic [3:0] remainder_o;
  logic       div_by_zero_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  divide #(.p_width(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .a_signed_i   (a_signed_i),
    .b_signed_i   (b_signed_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  // Reference: truncating integer division, results taken mod 16.
  function automatic void model(
    input  logic [3:0] a, input logic [3:0] b,
    input  logic as, input logic bs,
    output logic [3:0] q, output logic [3:0] r,
    output logic dz);
    int ai, bi, qi, ri;
    ai = (as && a[3]) ? int'(a) - 16 : int'(a);
    bi = (bs && b[3]) ? int'(b) - 16 : int'(b);
    if (bi == 0) begin
      q  = 4'hF;
      r  = a;
      dz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[3:0];
      r  = ri[3:0];
      dz = 1'b0;
    end
  endfunction

  // Drives one request and collects the result; lat = cycles from
  // accept edge to valid_o (20 means it never came).
  task automatic run_op(
    input  logic [3:0] a, input logic [3:0] b,
    input  logic as, input logic bs,
    output logic [3:0] q, output logic [3:0] r,
    output logic dz, output int lat, output logic rdy);
    @(negedge clk_i);
    rdy        = ready_o;
    valid_i    = 1'b1;
    a_i        = a;
    b_i        = b;
    a_signed_i = as;
    b_signed_i = bs;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i    = 1'b0;
    a_i        = 4'($urandom);
    b_i        = 4'($urandom);
    a_signed_i = 1'($urandom);
    b_signed_i = 1'($urandom);
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    q  = quotient_o;
    r  = remainder_o;
    dz = div_by_zero_o;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL reset_hs ready=%b valid=%b want 0 0",
               ready_o, valid_o);
    else n_pass++;
    n_total++;
    if ({quotient_o, remainder_o, div_by_zero_o} !== 9'd0)
      $display("FAIL reset_out q=%h r=%h dz=%b want 0 0 0",
               quotient_o, remainder_o, div_by_zero_o);
    else n_pass++;
    rst_i = 1'b0;
    #1;
    n_total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0)
      $display("FAIL reset_rel ready=%b valid=%b want 1 0",
               ready_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [3:0] ta [8] = '{4'd13, 4'd9, 4'd7, 4'd8,
                           4'd8, 4'd15, 4'd11, 4'd9};
    logic [3:0] tb [8] = '{4'd3, 4'd2, 4'd14, 4'd15,
                           4'd15, 4'd15, 4'd0, 4'd0};
    logic       tas[8] = '{0, 1, 1, 1, 0, 0, 1, 0};
    logic       tbs[8] = '{0, 1, 1, 1, 0, 1, 1, 0};
    logic [3:0] eq [8] = '{4'd4, 4'd13, 4'd13, 4'd8,
                           4'd0, 4'd1, 4'd15, 4'd15};
    logic [3:0] er [8] = '{4'd1, 4'd15, 4'd1, 4'd0,
                           4'd8, 4'd0, 4'd11, 4'd9};
    logic       edz[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic [3:0] q, r;
    logic       dz, rdy;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], tas[i], tbs[i], q, r, dz, lat, rdy);
      n_total++;
      if (lat !== 4)
        $display("FAIL dir%0d_lat got %0d want 4", i, lat);
      else n_pass++;
      n_total++;
      if (q !== eq[i] || r !== er[i] || dz !== edz[i])
        $display("FAIL dir%0d_res q=%h r=%h dz=%b want %h %h %b",
                 i, q, r, dz, eq[i], er[i], edz[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [3:0] a, b, q, r, mq, mr;
    logic       as, bs, dz, mdz, rdy;
    int         lat;
    for (int i = 0; i < 60; i++) begin
      a  = 4'($urandom);
      b  = (i % 10 == 0) ? 4'd0 : 4'($urandom);
      as = 1'($urandom);
      bs = 1'($urandom);
      model(a, b, as, bs, mq, mr, mdz);
      run_op(a, b, as, bs, q, r, dz, lat, rdy);
      n_total++;
      if (rdy !== 1'b1 || lat !== 4)
        $display("FAIL rnd%0d_timing rdy=%b lat=%0d want 1 4",
                 i, rdy, lat);
      else n_pass++;
      n_total++;
      if (q !== mq || r !== mr || dz !== mdz)
        $display("FAIL rnd%0d %h/%h s%b%b q=%h r=%h dz=%b want %h %h %b",
                 i, a, b, as, bs, q, r, dz, mq, mr, mdz);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int  lat;
    logic bad;
    @(negedge clk_i);
    valid_i = 1'b1;
    a_i = 4'd13; b_i = 4'd3;
    a_signed_i = 1'b0; b_signed_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    n_total++;
    if (lat !== 4)
      $display("FAIL bp_lat got %0d want 4", lat);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        valid_i = 1'b1;
        a_i = 4'd2; b_i = 4'd1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
      if (valid_o !== 1'b1 || ready_o !== 1'b0 ||
          quotient_o !== 4'd4 || remainder_o !== 4'd1 ||
          div_by_zero_o !== 1'b0)
        bad = 1'b1;
    end
    valid_i = 1'b0;
    n_total++;
    if (bad)
      $display("FAIL bp_hold v=%b rdy=%b q=%h r=%h want 1 0 4 1",
               valid_o, ready_o, quotient_o, remainder_o);
    else n_pass++;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    n_total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0)
      $display("FAIL bp_release rdy=%b v=%b want 1 0",
               ready_o, valid_o);
    else n_pass++;
    n_total++;
    if (quotient_o !== 4'd4 || remainder_o !== 4'd1)
      $display("FAIL bp_retain q=%h r=%h want 4 1",
               quotient_o, remainder_o);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    logic [3:0] q, r;
    logic       dz, rdy, seen;
    int         lat;
    @(negedge clk_i);
    valid_i = 1'b1;
    a_i = 4'd13; b_i = 4'd3;
    a_signed_i = 1'b0; b_signed_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL abort_rst rdy=%b v=%b want 0 0",
               ready_o, valid_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL abort_valid got %b want 0", seen);
    else n_pass++;
    run_op(4'd6, 4'd4, 1'b0, 1'b0, q, r, dz, lat, rdy);
    n_total++;
    if (rdy !== 1'b1 || lat !== 4 || q !== 4'd1 ||
        r !== 4'd2 || dz !== 1'b0)
      $display("FAIL abort_next rdy=%b lat=%0d q=%h r=%h dz=%b want 1 4 1 2 0",
               rdy, lat, q, r, dz);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int  idx[$];
    logic bad;
    @(negedge clk_i);
    valid_i = 1'b1;
    ready_i = 1'b1;
    a_i = 4'd14; b_i = 4'd5;
    a_signed_i = 1'b0; b_signed_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        idx.push_back(c);
        if (quotient_o !== 4'd2 || remainder_o !== 4'd4)
          bad = 1'b1;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    repeat (8) @(negedge clk_i);
    n_total++;
    if (idx.size() < 4 || bad)
      $display("FAIL b2b_results count=%0d bad=%b want >=4 0",
               idx.size(), bad);
    else n_pass++;
    bad = 1'b0;
    for (int i = 1; i < idx.size(); i++)
      if (idx[i] - idx[i-1] != 6) bad = 1'b1;
    n_total++;
    if (bad || idx.size() < 2)
      $display("FAIL b2b_period got spacing error=%b want period 6", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
